// File: rtl/mm_bus_pkg.sv
// mm_bus_pkg -- shared definitions for the mm_bus interconnect.
//   arb_state_e   : grant register state (IDLE / OWN)
//   DEF_SLV_BASE  : default packed slave base addresses (slave 0 in the low slice)
//   DEF_SLV_SIZE  : default packed slave window sizes
//   idx_w()       : width of an index into n items (never below 1 bit)
package mm_bus_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } arb_state_e;

  localparam logic [31:0] DEF_SLV_BASE = {16'h7000, 16'h0000};
  localparam logic [31:0] DEF_SLV_SIZE = {16'h0200, 16'h0800};

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mm_bus_arbiter.sv
// mm_bus_arbiter -- grant register for the mm_bus shared bus.
// Holds IDLE or OWN(k). An owner keeps the bus while its request stays high;
// when it drops, the next winner is taken on the same edge (no idle bubble).
// Winner selection:
//   MM_BUS_RR_ARB_EN defined   : round robin, search upward from pointer+1 mod NM
//   MM_BUS_RR_ARB_EN undefined : fixed priority, lowest index wins
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   m_req        : per-master request
//   m_grant      : registered one-hot-or-zero grant
//   own_vld      : a master currently owns the bus
//   own_idx      : index of the owning master (valid with own_vld)
module mm_bus_arbiter
  import mm_bus_pkg::*;
#(
  parameter  int NM = 2,
  localparam int IW = idx_w(NM)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [NM-1:0] m_req,
  output logic [NM-1:0] m_grant,
  output logic          own_vld,
  output logic [IW-1:0] own_idx
);

  arb_state_e    state_q;
  logic [IW-1:0] own_q;
  logic [NM-1:0] grant_q;
  logic          win_vld;
  logic [IW-1:0] win_idx;
  logic          need_arb;

`ifdef MM_BUS_RR_ARB_EN
  logic [IW-1:0] ptr_q;

  // Rank each requester by its distance past the pointer; nearest wins.
  always_comb begin
    int best;
    int dist;
    best    = NM;
    dist    = 0;
    win_vld = 1'b0;
    win_idx = '0;
    for (int i = 0; i < NM; i++) begin
      dist = (i + NM - 1 - int'(ptr_q)) % NM;
      if (m_req[i] && dist < best) begin
        best    = dist;
        win_vld = 1'b1;
        win_idx = IW'(i);
      end
    end
  end
`else
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int i = NM - 1; i >= 0; i--) begin
      if (m_req[i]) begin
        win_vld = 1'b1;
        win_idx = IW'(i);
      end
    end
  end
`endif

  // Re-arbitrate only from IDLE or when the owner has let go.
  assign need_arb = (state_q == ST_IDLE) || !m_req[own_q];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      own_q   <= '0;
      grant_q <= '0;
`ifdef MM_BUS_RR_ARB_EN
      ptr_q   <= IW'(NM - 1);
`endif
    end else if (need_arb) begin
      if (win_vld) begin
        state_q <= ST_OWN;
        own_q   <= win_idx;
        grant_q <= NM'(1) << win_idx;
`ifdef MM_BUS_RR_ARB_EN
        ptr_q   <= win_idx;
`endif
      end else begin
        state_q <= ST_IDLE;
        own_q   <= '0;
        grant_q <= '0;
      end
    end
  end

  assign m_grant = grant_q;
  assign own_vld = (state_q == ST_OWN);
  assign own_idx = own_q;

endmodule

// File: rtl/mm_bus.sv
// mm_bus -- single-clock shared bus: NM masters, NS memory-mapped slaves.
// The arbiter (mm_bus_arbiter) picks an owner; this module forwards the
// owner's address/strobe/data, decodes the address to a slave select, and
// returns the selected slave's read data one cycle later.
// Optional feature: MM_BUS_RR_ARB_EN selects round-robin arbitration
// (default build: fixed priority).
// Ports:
//   clk, reset_n            : clock, asynchronous active-low reset
//   m_req, m_wr             : per-master request / write strobe
//   m_addr, m_dout          : packed per-master address / write data
//   m_grant                 : one-hot-or-zero grant
//   m_din                   : read data broadcast to all masters
//   bus_err                 : decode error, one cycle after an unmapped access
//   s_sel                   : one-hot-or-zero slave select
//   s_addr, s_wr, s_din     : forwarded owner address / strobe / write data
//   s_dout                  : packed per-slave read data
module mm_bus
  import mm_bus_pkg::*;
#(
  parameter int                 NM       = 2,
  parameter int                 NS       = 2,
  parameter int                 AW       = 16,
  parameter int                 DW       = 64,
  parameter logic [NS*AW-1:0]   SLV_BASE = DEF_SLV_BASE,
  parameter logic [NS*AW-1:0]   SLV_SIZE = DEF_SLV_SIZE
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [NM-1:0]    m_req,
  input  logic [NM-1:0]    m_wr,
  input  logic [NM*AW-1:0] m_addr,
  input  logic [NM*DW-1:0] m_dout,
  output logic [NM-1:0]    m_grant,
  output logic [DW-1:0]    m_din,
  output logic             bus_err,
  output logic [NS-1:0]    s_sel,
  output logic [AW-1:0]    s_addr,
  output logic             s_wr,
  output logic [DW-1:0]    s_din,
  input  logic [NS*DW-1:0] s_dout
);

  localparam int IW = idx_w(NM);

  logic          own_vld;
  logic [IW-1:0] own_idx;
  logic          own_req;
  logic [NS-1:0] hit;
  logic [NS-1:0] hit_sel;
  logic [NS-1:0] sel_d, sel_q;
  logic          err_d, err_q;

  mm_bus_arbiter #(.NM(NM)) u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .m_req   (m_req),
    .m_grant (m_grant),
    .own_vld (own_vld),
    .own_idx (own_idx)
  );

  // Owner forwarding; everything reads zero while IDLE.
  always_comb begin
    s_addr  = '0;
    s_wr    = 1'b0;
    s_din   = '0;
    own_req = 1'b0;
    for (int k = 0; k < NM; k++) begin
      if (own_vld && own_idx == IW'(k)) begin
        s_addr  = m_addr[k*AW +: AW];
        s_wr    = m_wr[k];
        s_din   = m_dout[k*DW +: DW];
        own_req = m_req[k];
      end
    end
  end

  // Window compare one bit wider than the address so base+size cannot wrap.
  for (genvar i = 0; i < NS; i++) begin : g_dec
    logic [AW:0] lo, hi;
    assign lo     = {1'b0, SLV_BASE[i*AW +: AW]};
    assign hi     = lo + {1'b0, SLV_SIZE[i*AW +: AW]};
    assign hit[i] = ({1'b0, s_addr} >= lo) && ({1'b0, s_addr} < hi);
  end

  // Overlapping windows resolve to the lowest slave index.
  always_comb begin
    hit_sel = '0;
    for (int i = NS - 1; i >= 0; i--) begin
      if (hit[i]) hit_sel = NS'(1) << i;
    end
  end

  assign sel_d = (own_vld && own_req) ? hit_sel : '0;
  assign err_d = own_vld && own_req && (hit == '0);
  assign s_sel = sel_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sel_q <= '0;
      err_q <= 1'b0;
    end else begin
      sel_q <= sel_d;
      err_q <= err_d;
    end
  end

  // Read return path: slave chosen on the previous edge.
  always_comb begin
    m_din = '0;
    for (int i = 0; i < NS; i++) begin
      if (sel_q[i]) m_din = s_dout[i*DW +: DW];
    end
  end

  assign bus_err = err_q;

endmodule

// File: doc/mm_bus.md
MM_BUS -- requirements
Module: mm_bus

Interface
REQ-001 Parameter NM, default 2: number of masters (1..8).
REQ-002 Parameter NS, default 2: number of slaves (1..8).
REQ-003 Parameter AW, default 16: address width.
REQ-004 Parameter DW, default 64: data width.
REQ-005 Parameter SLV_BASE, default {16'h7000,16'h0000}: packed NS*AW slave base addresses; slave i occupies slice i.
REQ-006 Parameter SLV_SIZE, default {16'h0200,16'h0800}: packed NS*AW slave window sizes.
REQ-007 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-008 Port reset_n, input, 1: asynchronous active-low reset.
REQ-009 Port m_req, input, NM: per-master bus request.
REQ-010 Port m_wr, input, NM: per-master write strobe (1 = write).
REQ-011 Port m_addr, input, NM*AW: packed per-master address.
REQ-012 Port m_dout, input, NM*DW: packed per-master write data.
REQ-013 Port m_grant, output, NM: one-hot-or-zero grant.
REQ-014 Port m_din, output, DW: read data, broadcast to all masters.
REQ-015 Port bus_err, output, 1: decode-error flag.
REQ-016 Port s_sel, output, NS: one-hot-or-zero slave select.
REQ-017 Port s_addr, output, AW: forwarded address.
REQ-018 Port s_wr, output, 1: forwarded write strobe.
REQ-019 Port s_din, output, DW: forwarded write data.
REQ-020 Port s_dout, input, NS*DW: packed per-slave read data.

Function
REQ-021 Grant register: state IDLE (m_grant=0) or OWN(k) (m_grant=1<<k); updates only on clk edge, so a request is granted no earlier than the next edge.
REQ-022 IDLE, any m_req set: next edge -> OWN(winner); no requests -> stay IDLE.
REQ-023 OWN(k), m_req[k]=1: stay OWN(k); no preemption.
REQ-024 OWN(k), m_req[k]=0: next edge -> OWN(winner) if any other request is set, else IDLE; no idle bubble between owners.
REQ-025 Owner k: s_addr, s_wr, s_din equal master k's m_addr, m_wr, m_dout combinationally; in IDLE all three are 0.
REQ-026 Slave i hit: SLV_BASE[i] <= s_addr < SLV_BASE[i]+SLV_SIZE[i], evaluated in AW+1 bits so the window end never wraps.
REQ-027 s_sel: set bit = lowest-index hit slave, only while granted and the owner's m_req=1; otherwise 0; overlapping windows resolve to the lowest index.
REQ-028 s_sel is registered into sel_q each edge; m_din = s_dout slice selected by sel_q, or 0 when sel_q=0 (one-cycle read latency).
REQ-029 bus_err: registered; 1 for the cycle after an edge on which owner's m_req=1 and no slave hit; otherwise 0.
REQ-030 Round-robin pointer: holds last granted index; updates on each transition into OWN(k).

Reset
REQ-031 On reset_n low, asynchronously: state IDLE, m_grant=0, sel_q=0, bus_err=0, pointer=NM-1 so master 0 wins first; m_din=0 and s_* outputs=0 as a consequence.
REQ-032 Reset asserted mid-transfer drops the grant immediately; no state persists.

Configuration
REQ-033 Macro MM_BUS_RR_ARB_EN defined: winner = first requester searching upward from pointer+1, modulo NM.
REQ-034 Macro MM_BUS_RR_ARB_EN undefined: fixed priority, lowest-index requester wins; pointer logic is absent.

Structure
REQ-035 Package mm_bus_pkg holds state encoding (IDLE/OWN) and the default base/size constants.
REQ-036 Arbitration (REQ-021..024, 030, 033/034) lives in sub-module mm_bus_arbiter; decode and muxes live in mm_bus.

Verification
REQ-037 Reset, then m_req=2'b01, m_addr[0]=16'h0100: next edge m_grant=01, s_sel=01; following edge m_din=s_dout[0].
REQ-038 Both masters request from IDLE, RR enabled: master 0 granted; m_req[0] drops -> next edge m_grant=10 with no IDLE cycle.
REQ-039 Same as REQ-038, RR disabled, master 0 re-requests each time it releases: master 0 always wins; master 1 granted only when m_req[0]=0.
REQ-040 Owner address 16'h7200 (one past slave 1): s_sel=0, bus_err=1 next cycle, m_din=0; address 16'h71FF: s_sel=10, bus_err=0.
REQ-041 Assert reset_n low while m_grant=01 and a write is in progress: m_grant, s_wr, s_addr, s_din, and bus_err read 0 immediately, before any clock edge.
